// File: rtl/gato_pkg.sv
// Shared definitions for the push-button conditioning path of the tic-tac-toe board.
// Channel states, button indices (lower index wins arbitration) and counter sizing.
package gato_pkg;

  typedef enum logic [2:0] {
    ESPERA_SUELTO,
    REPOSO,
    FILTRO_PRESION,
    PRESIONADO,
    FILTRO_SUELTA
  } canal_estado_e;

  localparam int unsigned N_BTN      = 5;
  localparam int unsigned IDX_ELIGE  = 0;
  localparam int unsigned IDX_ARRIBA = 1;
  localparam int unsigned IDX_ABAJO  = 2;
  localparam int unsigned IDX_IZQ    = 3;
  localparam int unsigned IDX_DER    = 4;

  function automatic int unsigned cnt_width(
    input int unsigned a,
    input int unsigned b,
    input int unsigned c
  );
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/acondicionador_botones_if.sv
// Raw button inputs and conditioned one-cycle strobes of the button conditioner.
// master = button side / consumer, slave = conditioner.
interface acondicionador_botones_if;
  logic btn_arriba_raw;
  logic btn_abajo_raw;
  logic btn_izq_raw;
  logic btn_der_raw;
  logic btn_elige_raw;
  logic boton_arriba_reg;
  logic boton_abajo_reg;
  logic boton_izq_reg;
  logic boton_der_reg;
  logic boton_elige_reg;

  modport master (
    output btn_arriba_raw, btn_abajo_raw, btn_izq_raw,
    output btn_der_raw, btn_elige_raw,
    input  boton_arriba_reg, boton_abajo_reg, boton_izq_reg,
    input  boton_der_reg, boton_elige_reg
  );

  modport slave (
    input  btn_arriba_raw, btn_abajo_raw, btn_izq_raw,
    input  btn_der_raw, btn_elige_raw,
    output boton_arriba_reg, boton_abajo_reg, boton_izq_reg,
    output boton_der_reg, boton_elige_reg
  );
endinterface

// File: rtl/antirrebote_canal.sv
// One button channel: 2-flop synchroniser, debounce FSM with optional auto-repeat.
// Emits a registered single-cycle request per accepted press or repeat.
module antirrebote_canal
  import gato_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000,
  parameter bit          ACTIVE_HIGH_IN  = 1'b1,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic req_o
);

  localparam int unsigned CW =
    cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CW-1:0] DEB_C = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DLY_C = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] PER_C = CW'(REPEAT_PERIOD);

  logic [1:0]    sync_q, sync_d;
  canal_estado_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rep_q, rep_d;
  logic          req_q, req_d;
  logic          raw_pol;
  logic          sync;
  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] rep_thr;

  assign raw_pol = ACTIVE_HIGH_IN ? raw_i : ~raw_i;
  assign sync    = sync_q[1];
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  // rep_q: 0 while waiting for the first repeat, 1 once in period phase
  assign rep_thr = rep_q ? PER_C : DLY_C;
  assign req_o   = req_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= ESPERA_SUELTO;
      cnt_q   <= '0;
      rep_q   <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    sync_d  = {sync_q[0], raw_pol};
    state_d = state_q;
    cnt_d   = cnt_q;
    rep_d   = rep_q;
    unique case (state_q)
      ESPERA_SUELTO: begin
        if (sync) begin
          cnt_d = '0;
        end else if (cnt_inc >= DEB_C) begin
          state_d = REPOSO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      REPOSO: begin
        if (sync) begin
          state_d = FILTRO_PRESION;
          cnt_d   = '0;
        end
      end
      FILTRO_PRESION: begin
        if (!sync) begin
          state_d = REPOSO;
          cnt_d   = '0;
        end else if (cnt_inc >= DEB_C) begin
          state_d = PRESIONADO;
          cnt_d   = '0;
          rep_d   = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      PRESIONADO: begin
        if (!sync) begin
          state_d = FILTRO_SUELTA;
          cnt_d   = '0;
        end else if (REPEAT_EN) begin
          if (cnt_inc >= rep_thr) begin
            cnt_d = '0;
            rep_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      FILTRO_SUELTA: begin
        // a bounce back to pressed resumes in period phase
        if (sync) begin
          state_d = PRESIONADO;
          cnt_d   = '0;
          rep_d   = 1'b1;
        end else if (cnt_inc >= DEB_C) begin
          state_d = REPOSO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = ESPERA_SUELTO;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    req_d = 1'b0;
    unique case (state_q)
      FILTRO_PRESION: req_d = sync && (cnt_inc >= DEB_C);
      PRESIONADO:     req_d = REPEAT_EN && sync && (cnt_inc >= rep_thr);
      default:        req_d = 1'b0;
    endcase
  end

endmodule

// File: rtl/acondicionador_botones.sv
// Five debounced button channels behind a fixed-priority one-hot arbiter.
// Only the highest-priority request per cycle strobes; the rest are dropped.
module acondicionador_botones
  import gato_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000,
  parameter bit          ACTIVE_HIGH_IN  = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_all,
  acondicionador_botones_if.slave bus
);

  logic [N_BTN-1:0] raw;
  logic [N_BTN-1:0] req;
  logic [N_BTN-1:0] strobe_q, strobe_d;

  assign raw[IDX_ELIGE]  = bus.btn_elige_raw;
  assign raw[IDX_ARRIBA] = bus.btn_arriba_raw;
  assign raw[IDX_ABAJO]  = bus.btn_abajo_raw;
  assign raw[IDX_IZQ]    = bus.btn_izq_raw;
  assign raw[IDX_DER]    = bus.btn_der_raw;

  for (genvar i = 0; i < N_BTN; i++) begin : g_canal
    antirrebote_canal #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .ACTIVE_HIGH_IN  (ACTIVE_HIGH_IN),
      .REPEAT_EN       (i != IDX_ELIGE)
    ) u_canal (
      .clk   (clk),
      .rst_n (reset_all),
      .raw_i (raw[i]),
      .req_o (req[i])
    );
  end

  always_comb begin
    strobe_d = '0;
    priority case (1'b1)
      req[IDX_ELIGE]:  strobe_d[IDX_ELIGE]  = 1'b1;
      req[IDX_ARRIBA]: strobe_d[IDX_ARRIBA] = 1'b1;
      req[IDX_ABAJO]:  strobe_d[IDX_ABAJO]  = 1'b1;
      req[IDX_IZQ]:    strobe_d[IDX_IZQ]    = 1'b1;
      req[IDX_DER]:    strobe_d[IDX_DER]    = 1'b1;
      default:         strobe_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_all) begin
    if (!reset_all) begin
      strobe_q <= '0;
    end else begin
      strobe_q <= strobe_d;
    end
  end

  assign bus.boton_elige_reg  = strobe_q[IDX_ELIGE];
  assign bus.boton_arriba_reg = strobe_q[IDX_ARRIBA];
  assign bus.boton_abajo_reg  = strobe_q[IDX_ABAJO];
  assign bus.boton_izq_reg    = strobe_q[IDX_IZQ];
  assign bus.boton_der_reg    = strobe_q[IDX_DER];

endmodule

// File: tb/tb_acondicionador_botones.sv
// Bench for acondicionador_botones: run-length reference model feeding a
// strobe scoreboard, plus directed timing checks on the observed strobe log.
module tb_acondicionador_botones;

  localparam int unsigned DEB = 8;
  localparam int unsigned DLY = 20;
  localparam int unsigned PER = 5;

  typedef struct {
    int cyc;
    int idx;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset_all = 1'b0;
  logic [4:0] raw_tb = '0;
  logic [4:0] obs_w;
  int         edge_n = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  ev_t        expq[$];
  ev_t        obs_log[$];

  acondicionador_botones_if bus();

  assign bus.btn_elige_raw  = raw_tb[0];
  assign bus.btn_arriba_raw = raw_tb[1];
  assign bus.btn_abajo_raw  = raw_tb[2];
  assign bus.btn_izq_raw    = raw_tb[3];
  assign bus.btn_der_raw    = raw_tb[4];
  assign obs_w = {bus.boton_der_reg, bus.boton_izq_reg, bus.boton_abajo_reg,
                  bus.boton_arriba_reg, bus.boton_elige_reg};

  acondicionador_botones #(
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (DLY),
    .REPEAT_PERIOD   (PER),
    .ACTIVE_HIGH_IN  (1'b1)
  ) dut (
    .clk       (clk),
    .reset_all (reset_all),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Reference model: per button, run lengths of the level seen two edges late.
  bit [4:0] h1, h2;
  bit       ready[5];
  bit       down[5];
  int       ones[5];
  int       zeros[5];
  int       since[5];
  int       gap[5];

  always @(posedge clk) begin
    bit [4:0] rq;
    bit       s;
    bit       won;
    if (!reset_all) begin
      h1 = '0;
      h2 = '0;
      for (int i = 0; i < 5; i++) begin
        ready[i] = 0; down[i] = 0; ones[i] = 0;
        zeros[i] = 0; since[i] = 0; gap[i] = DLY;
      end
    end else begin
      rq = '0;
      for (int i = 0; i < 5; i++) begin
        s = h2[i];
        if (down[i]) begin
          if (!s) begin
            zeros[i]++;
            if (zeros[i] > DEB) begin
              down[i] = 0; ready[i] = 1; ones[i] = 0;
            end
          end else if (zeros[i] > 0) begin
            zeros[i] = 0; since[i] = 0; gap[i] = PER;
          end else if (i != 0) begin
            since[i]++;
            if (since[i] >= gap[i]) begin
              rq[i] = 1; since[i] = 0; gap[i] = PER;
            end
          end
        end else if (ready[i]) begin
          ones[i] = s ? ones[i] + 1 : 0;
          if (ones[i] > DEB) begin
            rq[i] = 1; down[i] = 1; ready[i] = 0;
            since[i] = 0; zeros[i] = 0; gap[i] = DLY;
          end
        end else begin
          zeros[i] = s ? 0 : zeros[i] + 1;
          if (zeros[i] >= DEB) begin
            ready[i] = 1; ones[i] = 0;
          end
        end
      end
      h2 = h1;
      h1 = raw_tb;
      won = 0;
      for (int i = 0; i < 5; i++) begin
        if (rq[i] && !won) begin
          expq.push_back('{edge_n + 2, i});
          won = 1;
        end
      end
    end
  end

  always @(negedge reset_all) expq.delete();

  function automatic int idx_of(input logic [4:0] v);
    for (int i = 0; i < 5; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Monitor: every observed strobe is matched against the scoreboard.
  always @(negedge clk) begin
    ev_t e;
    if (obs_w != 5'b0) begin
      n_tests++;
      obs_log.push_back('{edge_n, idx_of(obs_w)});
      if ($countones(obs_w) != 1) begin
        n_fail++;
        $display("FAIL onehot: outputs %b at edge %0d, required one-hot", obs_w, edge_n);
        if (expq.size() > 0) e = expq.pop_front();
      end else if (expq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected: outputs %b at edge %0d, required none", obs_w, edge_n);
      end else begin
        e = expq.pop_front();
        if (e.cyc != edge_n || obs_w != (5'b1 << e.idx)) begin
          n_fail++;
          $display("FAIL strobe: got %b at edge %0d, required %b at edge %0d",
                   obs_w, edge_n, 5'(5'b1 << e.idx), e.cyc);
        end
      end
    end else if (expq.size() > 0 && expq[0].cyc < edge_n) begin
      n_tests++;
      n_fail++;
      e = expq.pop_front();
      $display("FAIL missed: no strobe at edge %0d, required button %0d", e.cyc, e.idx);
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, got, exp);
    end
  endtask

  task automatic press(input logic [4:0] m, input int hold, output int t0);
    @(posedge clk);
    #1;
    raw_tb = m;
    t0 = edge_n + 1;
    repeat (hold) @(posedge clk);
    #1;
    raw_tb = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic check_log(input string nm, input int t0, input int idx,
                           input int n, input int o[5]);
    chk({nm, "_count"}, obs_log.size(), n);
    for (int k = 0; k < n && k < obs_log.size(); k++) begin
      chk({nm, "_offset"}, obs_log[k].cyc - t0, o[k]);
      chk({nm, "_button"}, obs_log[k].idx, idx);
    end
  endtask

  initial begin
    int t0;
    int t1;
    logic [4:0] m;
    int d;
    bit rs;

    repeat (3) begin
      @(negedge clk);
      chk("reset_outputs", int'(obs_w), 0);
    end
    @(posedge clk);
    #1;
    reset_all = 1'b1;
    idle(15);

    obs_log.delete();
    press(5'b00001, 40, t0);
    idle(20);
    check_log("clean_elige", t0, 0, 1, '{11, 0, 0, 0, 0});

    obs_log.delete();
    @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      raw_tb[3] = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      raw_tb[3] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
    end
    idle(20);
    chk("bounce_none", obs_log.size(), 0);

    obs_log.delete();
    press(5'b10000, 48, t0);
    idle(20);
    check_log("repeat_der", t0, 4, 5, '{11, 31, 36, 41, 46});

    obs_log.delete();
    press(5'b00110, 15, t0);
    idle(20);
    check_log("simul_arriba", t0, 1, 1, '{11, 0, 0, 0, 0});

    obs_log.delete();
    @(posedge clk);
    #1;
    raw_tb[2] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    reset_all = 1'b0;
    @(posedge clk);
    #1;
    reset_all = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    raw_tb[2] = 1'b0;
    idle(12);
    chk("rst_hold_none", obs_log.size(), 0);
    obs_log.delete();
    press(5'b00100, 15, t1);
    idle(20);
    check_log("rst_hold_fresh", t1, 2, 1, '{11, 0, 0, 0, 0});

    @(posedge clk);
    #1;
    raw_tb[0] = 1'b1;
    t0 = edge_n + 1;
    for (int k = 0; k < 40 && edge_n < t0 + 11; k++) @(negedge clk);
    #1;
    chk("async_pre", int'(obs_w), 1);
    reset_all = 1'b0;
    #1;
    chk("async_kill", int'(obs_w), 0);
    @(posedge clk);
    #1;
    reset_all = 1'b1;
    raw_tb = '0;
    idle(20);

    for (int s = 0; s < 40; s++) begin
      m  = 5'($urandom) & 5'($urandom);
      d  = $urandom_range(1, 30);
      rs = ($urandom_range(0, 14) == 0);
      @(posedge clk);
      #1;
      raw_tb = m;
      if (rs) begin
        reset_all = 1'b0;
        @(posedge clk);
        #1;
        reset_all = 1'b1;
      end
      repeat (d) @(posedge clk);
    end
    #1;
    raw_tb = '0;
    idle(40);
    chk("scoreboard_drained", expq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
